stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM for the stopwatch counter. Takes two raw push-button levels: start/stop and lap/reset.
- Drives the counter's count enable (st_signal) as a 1 ms tick strobe.
- Drives the counter's synchronous clear (cnt_reset).
- Drives a display-freeze flag (lap_hold).
- Sits between the board buttons and the counter; the display mux uses lap_hold and state.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
TICK_HZ, 1000, count-enable rate; one strobe per millisecond.
DEB_CYCLES, 500000, stable-sample count for the debounce filter (used only with the macro).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
btn_ss  in  1  raw start/stop button, asynchronous level.
btn_lr  in  1  raw lap/reset button, asynchronous level.
at_max  in  1  counter is at 15:59:59.999 (driven by the counter datapath).
st_signal  out  1  registered count enable to the counter; one-cycle pulse per tick.
cnt_reset  out  1  registered clear to the counter; one-cycle pulse.
lap_hold  out  1  registered; high means the display shows the latched lap value.
state  out  2  current FSM state, encoding below.

Behaviour:
- Input conditioning:
  - Each button goes through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~prev).
  - A level present before edge k produces a state change at edge k+2; the output is visible after that edge.
  - Holding a button produces exactly one event.
- Prescaler:
  - DIV = CLK_HZ/TICK_HZ; the counter width is clog2(DIV); the count runs 0..DIV-1.
  - A tick is generated when count == DIV-1, and the count wraps to 0.
  - Prescaler counts only in RUN and LAP, holds in PAUSE (the partial millisecond is kept), and is cleared to 0 in IDLE.
- States:
  - IDLE = 0: counter cleared, not counting.
  - RUN = 1: counting.
  - PAUSE = 2: frozen.
  - LAP = 3: counting, display frozen.
- Transitions (ss = start/stop rise, lr = lap/reset rise):
  - IDLE: ss -> RUN; lr ignored.
  - RUN: ss -> PAUSE; lr -> LAP.
  - LAP: lr -> RUN; ss -> PAUSE (lap_hold released).
  - PAUSE: ss -> RUN; lr -> IDLE, with cnt_reset = 1 for exactly one cycle.
- Simultaneous ss and lr in the same cycle: ss wins and lr is discarded.
- st_signal:
  - Is 1 for one cycle following each tick while in RUN/LAP, unless at_max = 1.
  - Never 1 in IDLE or PAUSE.
- Saturation: if at_max = 1 in RUN or LAP on a tick cycle:
  - st_signal is suppressed.
  - State goes to PAUSE and lap_hold goes to 0.
  - The counter holds at its maximum; the user must clear it via lr from PAUSE.
- lap_hold is 1 exactly while state == LAP (registered with the state).
- Reset values: state = IDLE, st_signal = 0, lap_hold = 0, prescaler = 0, synchronizer/edge flops = 0.
  - cnt_reset = 1 for the first cycle after reset deasserts, so the counter is cleared; then 0.
  - Reset asserted mid-operation (any state) overrides all events that cycle.

Optional Feature:
STOPWATCH_DEBOUNCE_EN:
- Defined: each synchronized button feeds a counter that must see DEB_CYCLES consecutive identical samples before the filtered level changes. Edge detection runs on the filtered level. Added latency = DEB_CYCLES cycles.
- Undefined: edge detection runs directly on sync2; DEB_CYCLES is unused and no debounce logic is synthesized.

Decomposition:
- Package stopwatch_pkg holds:
  - state encodings IDLE/RUN/PAUSE/LAP (2-bit);
  - the DIV computation and the clog2 helper;
  - the max-time constants (15, 59, 59, 999) shared with the counter.
- One sub-module, btn_edge: synchronizer + optional debounce + rise pulse. It is instanced twice (ss, lr).
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan:
All scenarios use CLK_HZ = 10000, TICK_HZ = 1000 (DIV = 10), debounce off.
1. Reset held 3 cycles then released -> state = 0, cnt_reset = 1 on the first cycle after release only, st_signal = 0 for 100 cycles.
2. Pulse btn_ss 1 cycle from IDLE -> state = 1 two edges later; st_signal pulses every 10 cycles; 5 pulses in 50 cycles.
3. RUN, press lr -> state = 3, lap_hold = 1, st_signal continues every 10 cycles. Press lr again -> state = 1, lap_hold = 0.
4. RUN for 14 clocks, ss -> PAUSE, wait 100 cycles (no st_signal), ss -> RUN -> next st_signal after 6 cycles (partial count kept).
5. PAUSE, btn_ss and btn_lr rise in the same cycle -> state = 1, no cnt_reset. Then ss, then lr -> state = 0, cnt_reset = 1 for exactly one cycle.
6. RUN with at_max forced to 1 -> at the next tick st_signal stays 0 and state = 2; lr -> state = 0, cnt_reset pulse.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch control path and counter datapath:
//   - sw_state_e : 2-bit FSM state encoding (IDLE/RUN/PAUSE/LAP)
//   - clog2 / cnt_width / calc_div : sizing helpers for the prescaler and
//     the optional debounce counter
//   - MAX_* : time value at which the counter saturates (15:59:59.999)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_e;

    // Saturation point of the counter datapath.
    localparam int MAX_HOURS   = 15;
    localparam int MAX_MINUTES = 59;
    localparam int MAX_SECONDS = 59;
    localparam int MAX_MILLIS  = 999;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    // Clock cycles per count-enable strobe.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge
//   Conditions one raw push-button level into a single-cycle rise pulse.
//   2-FF synchronizer -> (optional debounce filter) -> rising-edge detector.
//   A level present before edge k gives a pulse during the cycle after
//   edge k+1, so a consumer registering on the pulse changes at edge k+2.
//   Optional feature macro: STOPWATCH_DEBOUNCE_EN (adds DEB_CYCLES latency).
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-high reset
//   btn_raw in  asynchronous button level
//   rise    out one-cycle pulse per press (holding gives one pulse)
module btn_edge
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DEB_W = cnt_width(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;
    logic             filt_q;
    logic             filt_d;

    // Count consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the run.
    always_comb begin
        deb_cnt_d = '0;
        filt_d    = filt_q;
        if (sync2_q != filt_q) begin
            if (deb_cnt_q >= DEB_W'(DEB_CYCLES - 1)) begin
                filt_d    = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_q <= '0;
            filt_q    <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            filt_q    <= filt_d;
        end
    end

    assign level = filt_q;
`else
    // Without the filter the threshold has no meaning; keep it referenced.
    logic deb_cycles_unused;
    assign deb_cycles_unused = (DEB_CYCLES != 0);
    assign level             = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control FSM and millisecond prescaler for the stopwatch counter.
//   Optional feature macro: STOPWATCH_DEBOUNCE_EN (button debounce filter).
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   btn_ss    in  raw start/stop button level
//   btn_lr    in  raw lap/reset button level
//   at_max    in  counter sits at 15:59:59.999
//   st_signal out registered count enable, one pulse per tick in RUN/LAP
//   cnt_reset out registered counter clear pulse
//   lap_hold  out registered display freeze, high exactly in LAP
//   state     out current FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 LAP)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic       at_max,
    output logic       st_signal,
    output logic       cnt_reset,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int              DIV      = calc_div(CLK_HZ, TICK_HZ);
    localparam int              PRE_W    = cnt_width(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    // Index 0 = start/stop, index 1 = lap/reset.
    logic [1:0] btn_raw;
    logic [1:0] btn_rise;
    logic       ss_rise;
    logic       lr_rise;

    assign btn_raw = {btn_lr, btn_ss};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_edge #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_btn_edge (
                .clk     (clk),
                .reset   (reset),
                .btn_raw (btn_raw[gi]),
                .rise    (btn_rise[gi])
            );
        end
    endgenerate

    assign ss_rise = btn_rise[0];
    assign lr_rise = btn_rise[1];

    sw_state_e        state_q;
    sw_state_e        state_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             st_signal_q;
    logic             st_signal_d;
    logic             cnt_reset_q;
    logic             cnt_reset_d;
    logic             lap_hold_q;
    logic             lap_hold_d;
    logic             tick;
    logic             saturate;

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        tick        = 1'b0;
        st_signal_d = 1'b0;
        cnt_reset_d = 1'b0;

        // Prescaler: cleared in IDLE, frozen in PAUSE so the partial
        // millisecond survives a pause/resume.
        if (state_q == IDLE) begin
            pre_d = '0;
        end else if ((state_q == RUN) || (state_q == LAP)) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        // A tick at the maximum time is swallowed and stops the watch.
        saturate    = tick & at_max;
        st_signal_d = tick & ~at_max;

        // Start/stop is tested first everywhere so it wins over lap/reset.
        case (state_q)
            IDLE: begin
                if (ss_rise) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (saturate || ss_rise) begin
                    state_d = PAUSE;
                end else if (lr_rise) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (saturate || ss_rise) begin
                    state_d = PAUSE;
                end else if (lr_rise) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (ss_rise) begin
                    state_d = RUN;
                end else if (lr_rise) begin
                    state_d     = IDLE;
                    cnt_reset_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        lap_hold_d = (state_d == LAP);
    end

    // cnt_reset resets high so the counter is also cleared during the first
    // cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            st_signal_q <= 1'b0;
            cnt_reset_q <= 1'b1;
            lap_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            st_signal_q <= st_signal_d;
            cnt_reset_q <= cnt_reset_d;
            lap_hold_q  <= lap_hold_d;
        end
    end

    assign st_signal = st_signal_q;
    assign cnt_reset = cnt_reset_q;
    assign lap_hold  = lap_hold_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with CLK_HZ=10000, TICK_HZ=1000
//   (prescaler divides by 10), debounce filter not compiled in.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_ss;
    logic       btn_lr;
    logic       at_max;
    logic       st_signal;
    logic       cnt_reset;
    logic       lap_hold;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    int st_seen  = 0;
    int clr_seen = 0;

    stopwatch_ctrl #(
        .CLK_HZ     (10000),
        .TICK_HZ    (1000),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_ss    (btn_ss),
        .btn_lr    (btn_lr),
        .at_max    (at_max),
        .st_signal (st_signal),
        .cnt_reset (cnt_reset),
        .lap_hold  (lap_hold),
        .state     (state)
    );

    always #5 clk = ~clk;

    // One row: press buttons for one cycle (at_max held for the row), then
    // run 2+wait_cyc more cycles and compare the final state and the number
    // of st_signal / cnt_reset pulses seen in the whole window.
    typedef struct {
        logic       ss;
        logic       lr;
        logic       amax;
        int         wait_cyc;
        logic [1:0] exp_state;
        logic       exp_lap;
        int         exp_st;
        int         exp_clr;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    vec_t exp_q [$];
    int   lat_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (st_signal === 1'b1) st_seen++;
        if (cnt_reset === 1'b1) clr_seen++;
    endtask

    // One-cycle press; the state has changed when this returns.
    task automatic press(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
        step();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t cur;
        int   got;
        int   exp_lat;

        //            ss    lr    amax  wait st    lap   st clr
        vecs[0] = '{1'b0, 1'b1, 1'b0, 10, 2'd0, 1'b0, 0, 0}; // lr ignored in IDLE
        vecs[1] = '{1'b1, 1'b0, 1'b0, 50, 2'd1, 1'b0, 5, 0}; // start, 5 ticks
        vecs[2] = '{1'b0, 1'b1, 1'b0, 50, 2'd3, 1'b1, 5, 0}; // lap keeps counting
        vecs[3] = '{1'b0, 1'b1, 1'b0,  7, 2'd1, 1'b0, 1, 0}; // lap release
        vecs[4] = '{1'b1, 1'b0, 1'b0, 20, 2'd2, 1'b0, 0, 0}; // pause, frozen
        vecs[5] = '{1'b1, 1'b1, 1'b0, 10, 2'd1, 1'b0, 1, 0}; // both: ss wins
        vecs[6] = '{1'b1, 1'b0, 1'b0,  5, 2'd2, 1'b0, 0, 0}; // pause again
        vecs[7] = '{1'b0, 1'b1, 1'b0,  5, 2'd0, 1'b0, 0, 1}; // clear to IDLE
        vecs[8] = '{1'b1, 1'b0, 1'b1, 12, 2'd2, 1'b0, 0, 0}; // saturate in RUN
        vecs[9] = '{1'b0, 1'b1, 1'b0,  5, 2'd0, 1'b0, 0, 1}; // clear after max

        // Reset held 3 cycles
        reset  = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        at_max = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_state", state, 0);
        check("rst_lap_hold", lap_hold, 0);
        check("rst_cnt_reset_first", cnt_reset, 1);
        step();
        check("rst_cnt_reset_second", cnt_reset, 0);
        st_seen = 0;
        repeat (100) step();
        check("rst_idle_st_count", st_seen, 0);
        check("rst_idle_state", state, 0);

        // Table-driven rows through the scoreboard queue
        for (int i = 0; i < NVEC; i++) begin
            exp_q.push_back(vecs[i]);
            st_seen  = 0;
            clr_seen = 0;
            at_max   = vecs[i].amax;
            btn_ss   = vecs[i].ss;
            btn_lr   = vecs[i].lr;
            step();
            btn_ss = 1'b0;
            btn_lr = 1'b0;
            repeat (2 + vecs[i].wait_cyc) step();
            cur = exp_q.pop_front();
            check($sformatf("row%0d_state", i), state, cur.exp_state);
            check($sformatf("row%0d_lap_hold", i), lap_hold, cur.exp_lap);
            check($sformatf("row%0d_st_pulses", i), st_seen, cur.exp_st);
            check($sformatf("row%0d_clr_pulses", i), clr_seen, cur.exp_clr);
        end
        at_max = 1'b0;

        // Exact two-edge latency of a start press
        btn_ss = 1'b1;
        step();
        btn_ss = 1'b0;
        step();
        check("latency_edge_k1", state, 0);
        step();
        check("latency_edge_k2", state, 1);

        // 14 clocks of RUN, pause, 100 idle cycles, resume after 6
        repeat (11) step();
        press(1'b1, 1'b0);
        check("pause_state", state, 2);
        st_seen = 0;
        repeat (100) step();
        check("pause_no_st", st_seen, 0);
        press(1'b1, 1'b0);
        check("resume_state", state, 1);
        lat_q.push_back(6);
        got = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (st_signal === 1'b1) begin
                got = k;
                break;
            end
        end
        exp_lat = lat_q.pop_front();
        check("resume_first_tick_latency", got, exp_lat);

        // cnt_reset lasts exactly one cycle on PAUSE -> IDLE
        press(1'b1, 1'b0);
        btn_lr = 1'b1;
        step();
        btn_lr = 1'b0;
        step();
        check("clr_pre_state", state, 2);
        check("clr_pre_pulse", cnt_reset, 0);
        step();
        check("clr_state", state, 0);
        check("clr_pulse", cnt_reset, 1);
        step();
        check("clr_pulse_end", cnt_reset, 0);

        // Saturation while in LAP drops lap_hold
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("lapmax_lap_hold", lap_hold, 1);
        at_max  = 1'b1;
        st_seen = 0;
        repeat (6) step();
        check("lapmax_before_tick", state, 3);
        step();
        check("lapmax_state", state, 2);
        check("lapmax_lap_hold_off", lap_hold, 0);
        check("lapmax_st_count", st_seen, 0);
        at_max = 1'b0;
        press(1'b0, 1'b1);
        check("lapmax_cleared", state, 0);

        // Reset mid-run overrides a start press in the same cycle
        press(1'b1, 1'b0);
        repeat (5) step();
        reset  = 1'b1;
        btn_ss = 1'b1;
        step();
        reset  = 1'b0;
        btn_ss = 1'b0;
        check("midrst_state", state, 0);
        check("midrst_cnt_reset", cnt_reset, 1);
        check("midrst_st", st_signal, 0);
        step();
        check("midrst_cnt_reset_end", cnt_reset, 0);
        repeat (4) step();
        check("midrst_press_dropped", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
